// File: rtl/uart_rx_core.sv
`timescale 1ns/1ps
// uart_rx_core: 8N1 asynchronous serial receiver, LSB first, 16x oversampled.
//
// The line is sampled at mid-bit of every start, data and stop bit. Each
// completed byte goes to a single holding register that the consumer reads
// and releases with rx_ack.
//
// Optional feature (compile-time macro CONFIG_UART_RX_MAJORITY_EN):
//   defined   - each bit value is the 2-of-3 majority of the line at phases 6,7,8;
//               decisions are taken at phase 8.
//   undefined - single sample of the line at phase 7.
//
// Parameters:
//   REFCLK  input clock frequency in Hz
//   BAUD    line rate in bit/s
//   DIV     prescaler terminal count, REFCLK/(16*BAUD), must be >= 1
//
// Ports:
//   wb_clk_i  in   system clock, rising edge
//   wb_rst_i  in   asynchronous active-high reset
//   rxd       in   serial line, idle high, asynchronous to wb_clk_i
//   rx_ack    in   one-clock pulse, consumer took rx_data; clears ready/flags
//   rx_data   out  last received byte
//   rx_ready  out  holding register holds an unread byte
//   rx_ferr   out  framing error (stop bit sampled low), sticky until ack/load
//   rx_ovr    out  overrun (byte completed while rx_ready set), sticky until ack
//   rx_busy   out  frame reception in progress
module uart_rx_core #(
    parameter int unsigned REFCLK = 50000000,
    parameter int unsigned BAUD   = 115200,
    parameter int unsigned DIV    = REFCLK / (16 * BAUD)
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       rxd,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       rx_ferr,
    output logic       rx_ovr,
    output logic       rx_busy
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PreTc = PW'(DIV - 1);

`ifdef CONFIG_UART_RX_MAJORITY_EN
    localparam logic [3:0] PhDecide = 4'd8;
`else
    localparam logic [3:0] PhDecide = 4'd7;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    // Synchronizer and prescaler
    logic          r_rxd_meta;
    logic          r_rs;
    logic [PW-1:0] r_prescale;
    logic          w_tick16;

    // Receive FSM state
    state_e        r_state;
    state_e        w_state_nxt;
    logic [3:0]    r_ph;
    logic [3:0]    w_ph_nxt;
    logic [2:0]    r_bitn;
    logic [2:0]    w_bitn_nxt;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_nxt;
    logic          w_bit;
    logic          w_load;
    logic          w_ferr_set;

    // Holding register and flags
    logic [7:0]    r_data;
    logic          r_ready;
    logic          r_ferr;
    logic          r_ovr;

    // Two-flop synchronizer; resets to the idle line level.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_rxd_meta <= 1'b1;
            r_rs       <= 1'b1;
        end else begin
            r_rxd_meta <= rxd;
            r_rs       <= r_rxd_meta;
        end
    end

    // Free-running 16x baud prescaler.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_prescale <= '0;
        end else if (w_tick16) begin
            r_prescale <= '0;
        end else begin
            r_prescale <= r_prescale + 1'b1;
        end
    end

    assign w_tick16 = (r_prescale == PreTc);

`ifdef CONFIG_UART_RX_MAJORITY_EN
    logic r_s6;
    logic r_s7;

    // Early samples for the vote; the third sample is the live value at phase 8.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_s6 <= 1'b1;
            r_s7 <= 1'b1;
        end else if (w_tick16) begin
            if (r_ph == 4'd6) begin
                r_s6 <= r_rs;
            end
            if (r_ph == 4'd7) begin
                r_s7 <= r_rs;
            end
        end
    end

    assign w_bit = (r_s6 & r_s7) | (r_s6 & r_rs) | (r_s7 & r_rs);
`else
    assign w_bit = r_rs;
`endif

    // FSM state register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= StIdle;
            r_ph    <= 4'd0;
            r_bitn  <= 3'd0;
            r_shift <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_ph    <= w_ph_nxt;
            r_bitn  <= w_bitn_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // FSM next-state logic; everything advances only on tick16.
    always_comb begin
        w_state_nxt = r_state;
        w_ph_nxt    = r_ph;
        w_bitn_nxt  = r_bitn;
        w_shift_nxt = r_shift;
        w_load      = 1'b0;
        w_ferr_set  = 1'b0;

        if (w_tick16) begin
            unique case (r_state)
                StIdle: begin
                    if (!r_rs) begin
                        w_state_nxt = StStart;
                        w_ph_nxt    = 4'd0;
                    end
                end

                StStart: begin
                    w_ph_nxt = r_ph + 4'd1;
                    if ((r_ph == PhDecide) && w_bit) begin
                        // Line back high at mid start bit: noise, not a frame.
                        w_state_nxt = StIdle;
                    end else if (r_ph == 4'd15) begin
                        // Phase wraps to 0, so data bit 0 starts a full bit later.
                        w_state_nxt = StData;
                        w_bitn_nxt  = 3'd0;
                    end
                end

                StData: begin
                    w_ph_nxt = r_ph + 4'd1;
                    if (r_ph == PhDecide) begin
                        w_shift_nxt[r_bitn] = w_bit;
                    end
                    if (r_ph == 4'd15) begin
                        if (r_bitn == 3'd7) begin
                            w_state_nxt = StStop;
                        end else begin
                            w_bitn_nxt = r_bitn + 3'd1;
                        end
                    end
                end

                StStop: begin
                    w_ph_nxt = r_ph + 4'd1;
                    if (r_ph == PhDecide) begin
                        if (w_bit) begin
                            w_load      = 1'b1;
                            w_state_nxt = StIdle;
                        end else begin
                            w_ferr_set  = 1'b1;
                            w_state_nxt = StBreak;
                        end
                    end
                end

                StBreak: begin
                    // Hold here while the line stays low so a break flags once.
                    if (r_rs) begin
                        w_state_nxt = StIdle;
                    end
                end

                default: begin
                    w_state_nxt = StIdle;
                end
            endcase
        end
    end

    // Holding register and status flags.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_data  <= 8'h00;
            r_ready <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else if (w_load) begin
            // A load beats a simultaneous ack; the ack still suppresses overrun.
            r_data  <= r_shift;
            r_ready <= 1'b1;
            r_ferr  <= 1'b0;
            if (rx_ack) begin
                r_ovr <= 1'b0;
            end else if (r_ready) begin
                r_ovr <= 1'b1;
            end
        end else begin
            if (rx_ack) begin
                r_ready <= 1'b0;
                r_ferr  <= 1'b0;
                r_ovr   <= 1'b0;
            end
            if (w_ferr_set) begin
                r_ferr <= 1'b1;
            end
        end
    end

    assign rx_data  = r_data;
    assign rx_ready = r_ready;
    assign rx_ferr  = r_ferr;
    assign rx_ovr   = r_ovr;
    assign rx_busy  = (r_state != StIdle);

endmodule

// File: tb/tb_uart_rx_core.sv
`timescale 1ns/1ps
// tb_uart_rx_core: scoreboard bench for uart_rx_core at 50 MHz / 115200 baud.
// The stimulus process transmits frames and queues the expected bytes; a
// separate monitor acknowledges each presented byte and compares it.
module tb_uart_rx_core;

    localparam int DIV = 27;
    localparam int BIT = 16 * DIV;
`ifdef CONFIG_UART_RX_MAJORITY_EN
    localparam int DEC_PH = 8;
    localparam logic [7:0] GLITCH_EXP = 8'h00;
`else
    localparam int DEC_PH = 7;
    localparam logic [7:0] GLITCH_EXP = 8'h08;
`endif
    // Clocks from the start-detect tick to the stop-bit decision edge.
    localparam int LOAD_LAT = (16 * 9 + DEC_PH + 1) * DIV;
    localparam int LAT_MAX  = (19 * BIT) / 2 + 60;

    logic       wb_clk_i = 1'b0;
    logic       wb_rst_i = 1'b1;
    logic       rxd      = 1'b1;
    logic       ack_mon  = 1'b0;
    logic       ack_stim = 1'b0;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_ferr;
    logic       rx_ovr;
    logic       rx_busy;

    assign rx_ack = ack_mon | ack_stim;

    uart_rx_core #(
        .REFCLK(50000000),
        .BAUD  (115200)
    ) dut (
        .wb_clk_i(wb_clk_i),
        .wb_rst_i(wb_rst_i),
        .rxd     (rxd),
        .rx_ack  (rx_ack),
        .rx_data (rx_data),
        .rx_ready(rx_ready),
        .rx_ferr (rx_ferr),
        .rx_ovr  (rx_ovr),
        .rx_busy (rx_busy)
    );

    always #10 wb_clk_i = ~wb_clk_i;

    // Edges since reset release; after edge k this reads k+1.
    int n_edge = 0;
    always @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) n_edge <= 0;
        else          n_edge <= n_edge + 1;
    end

    logic ferr_q = 1'b0;
    int   ferr_rises = 0;
    always @(posedge wb_clk_i) begin
        ferr_q <= rx_ferr;
        if (rx_ferr && !ferr_q) ferr_rises <= ferr_rises + 1;
    end

    typedef struct {
        logic [7:0] data;
        int         start;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    bit   auto_ack = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_le(input string name, input int act, input int lim);
        tests++;
        if (act > lim) begin
            fails++;
            $display("FAIL %s: got %0d, required <= %0d at %0t", name, act, lim, $time);
        end
    endtask

    // Hold the line at v for n clock edges; always returns just after an edge.
    task automatic tx_level(input logic v, input int n);
        rxd = v;
        repeat (n) begin
            @(posedge wb_clk_i);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        tx_level(1'b0, BIT);
        for (int i = 0; i < 8; i++) tx_level(b[i], BIT);
        tx_level(stop, BIT);
    endtask

    task automatic send_exp(input logic [7:0] b);
        exp_t e;
        e.data  = b;
        e.start = n_edge;
        sb.push_back(e);
        send_frame(b, 1'b1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 3000) begin
            @(posedge wb_clk_i);
            #1;
            k++;
        end
        chk("drain_pending", sb.size(), 0);
        repeat (4) begin
            @(posedge wb_clk_i);
            #1;
        end
    endtask

    // Start the next frame so its falling edge reaches the detector just before a tick.
    task automatic align();
        do begin
            @(posedge wb_clk_i);
            #1;
        end while ((n_edge % DIV) != 24);
    endtask

    task automatic pulse_stim_ack();
        ack_stim = 1'b1;
        @(posedge wb_clk_i);
        #1;
        ack_stim = 1'b0;
    endtask

    // Monitor: consume each presented byte and check it against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge wb_clk_i);
            if (auto_ack && rx_ready && !wb_rst_i) begin
                if (sb.size() == 0) begin
                    chk("unexpected_byte", rx_data, 32'h100);
                end else begin
                    e = sb.pop_front();
                    chk("rx_data", rx_data, e.data);
                    chk("rx_ferr_on_load", rx_ferr, 0);
                    chk("rx_ovr_on_load", rx_ovr, 0);
                    chk_le("ready_latency", n_edge - e.start, LAT_MAX);
                end
                ack_mon = 1'b1;
                @(negedge wb_clk_i);
                ack_mon = 1'b0;
                chk("ready_after_ack", rx_ready, 0);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [7:0] b;

        // Reset state
        #55;
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_rx_ferr", rx_ferr, 0);
        chk("rst_rx_ovr", rx_ovr, 0);
        chk("rst_rx_busy", rx_busy, 0);
        @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b0;
        tx_level(1'b1, 20);

        // Basic byte
        send_exp(8'h55);
        drain();

        // Short low glitch is a false start
        tx_level(1'b0, 40);
        tx_level(1'b1, BIT);
        chk("glitch_busy", rx_busy, 0);
        chk("glitch_ready", rx_ready, 0);

        // Framing error followed by a held-low line
        base = ferr_rises;
        send_frame(8'hA3, 1'b0);
        tx_level(1'b0, 3 * BIT);
        chk("break_busy", rx_busy, 1);
        chk("break_ready", rx_ready, 0);
        chk("break_ferr", rx_ferr, 1);
        chk("break_ferr_count", ferr_rises - base, 1);
        tx_level(1'b1, BIT);
        chk("break_exit_busy", rx_busy, 0);
        chk("break_ferr_once", ferr_rises - base, 1);
        send_exp(8'h0F);
        drain();

        // Random traffic with random idle gaps
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom_range(0, 255));
            tx_level(1'b1, $urandom_range(0, 200));
            send_exp(b);
        end
        drain();

        // Mid-bit glitch on bit 3 of 0x00
        align();
        begin
            exp_t e;
            e.data  = GLITCH_EXP;
            e.start = n_edge;
            sb.push_back(e);
        end
        tx_level(1'b0, 1931);
        tx_level(1'b1, DIV);
        tx_level(1'b0, 9 * BIT - 1931 - DIV);
        tx_level(1'b1, BIT);
        drain();

        // Overrun, then ack coinciding with a load
        auto_ack = 1'b0;
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        tx_level(1'b1, 10);
        chk("ovr_data", rx_data, 8'h34);
        chk("ovr_ready", rx_ready, 1);
        chk("ovr_flag", rx_ovr, 1);
        align();
        fork
            send_frame(8'h56, 1'b1);
            begin
                repeat (LOAD_LAT + 2) @(posedge wb_clk_i);
                #1;
                ack_stim = 1'b1;
                @(posedge wb_clk_i);
                #1;
                ack_stim = 1'b0;
                chk("ackload_data", rx_data, 8'h56);
                chk("ackload_ready", rx_ready, 1);
                chk("ackload_ovr", rx_ovr, 0);
            end
        join
        pulse_stim_ack();
        chk("ackload_cleared", rx_ready, 0);

        // Reset in the middle of a frame
        send_frame(8'hC3, 1'b1);
        tx_level(1'b1, 10);
        chk("pre_rst_data", rx_data, 8'hC3);
        chk("pre_rst_ready", rx_ready, 1);
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (5 * BIT + BIT / 2) @(posedge wb_clk_i);
                #1;
                wb_rst_i = 1'b1;
                #1;
                chk("midrst_data", rx_data, 0);
                chk("midrst_ready", rx_ready, 0);
                chk("midrst_busy", rx_busy, 0);
                chk("midrst_ferr", rx_ferr, 0);
                chk("midrst_ovr", rx_ovr, 0);
            end
        join
        @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b0;
        tx_level(1'b1, 30);
        auto_ack = 1'b1;
        send_exp(8'h81);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Asynchronous serial receiver: 8 data bits, no parity, 1 stop bit, LSB first.
- Receiving end of the host-side serial link. The bench transmitter drives the rxd line bit by bit at the configured baud rate.
- Sits between the board UART RX pin and the console/peripheral register logic.
- Oversamples the line at 16x the baud rate and hands each completed byte to a single holding register with ready/acknowledge handshake.

Parameters:
REFCLK, 50000000, input clock frequency in Hz
BAUD, 115200, line rate in bit/s
DIV, REFCLK/(16*BAUD), prescaler terminal count, integer floor; must be >=1 (27 for defaults)

Ports:
wb_clk_i  input  1  system clock, all logic on rising edge
wb_rst_i  input  1  asynchronous active-high reset
rxd       input  1  serial line, idle high, asynchronous to wb_clk_i
rx_ack    input  1  one-clock pulse: consumer has taken rx_data, clears rx_ready
rx_data   output 8  last received byte
rx_ready  output 1  holding register contains an unread byte
rx_ferr   output 1  framing error flag (stop bit sampled low)
rx_ovr    output 1  overrun flag (byte completed while rx_ready was set)
rx_busy   output 1  frame reception in progress (state != IDLE)

Behaviour:
- Reset (asynchronous, wb_rst_i=1): rx_data=0, rx_ready=0, rx_ferr=0, rx_ovr=0, rx_busy=0, state IDLE, prescaler=0, synchronizer flops=1.
- Input synchronizer: two flops on rxd. All decisions use the synchronized value rs.
- Prescaler: free-running counter 0..DIV-1. Generates tick16, a one-clock enable at terminal count.
- Bit phase counter ph: 4 bits, advances on tick16.
- States and transitions:
  - IDLE: rs==0 sampled on tick16 -> START, ph=0.
  - START: at ph==7, if rs==1 it is a false start -> IDLE; else -> DATA, bit index n=0, ph=0 at the next tick.
  - DATA: sample rs at ph==7 of each bit into shift[n] (LSB first). After 16 ticks, n++. After n==7 completes -> STOP.
  - STOP: at ph==7:
    - rs==1: rx_data<=shift, rx_ready<=1, rx_ferr<=0. If rx_ready was already 1 and rx_ack is not asserted in the same cycle, rx_ovr<=1. -> IDLE.
    - rs==0: rx_ferr<=1, rx_data unchanged, rx_ready unchanged -> BREAK.
  - BREAK: wait for rs==1 on a tick16 -> IDLE. A continuous low line produces exactly one rx_ferr assertion, not repeated frames.
- Sampling point is mid-bit (ph==7); prescaler jitter is at most 1/16 bit.
- rx_ready update timing: rises in the clock after the STOP-state mid-bit sample. Worst-case latency from the start-bit falling edge is 9.5 bit times + 2 synchronizer clocks + 1 tick16.
- rx_ack rules:
  - Clears rx_ready, rx_ferr and rx_ovr on the next clock.
  - Ack in the same cycle as a new byte load: the load wins (rx_ready stays 1, new data), and no overrun is flagged.
  - Ack with rx_ready=0: no effect other than clearing flags.
- Overrun: new data overwrites rx_data. rx_ovr stays sticky until rx_ack.
- rx_busy: 1 in START/DATA/STOP/BREAK, combinational decode of registered state.
- Reset mid-frame: abort immediately. Partial byte discarded; reception restarts on the next falling edge after release.

Optional Feature:
- Macro CONFIG_UART_RX_MAJORITY_EN.
- Defined: each bit value (start, data, stop) is the 2-of-3 majority of rs sampled at ph==6,7,8. The state decision is made at ph==8 instead of ph==7; all other timing is unchanged. A single-tick glitch inside a bit does not corrupt it.
- Undefined: single sample at ph==7 as described above.

Test Plan:
- Send 0x55 at 115200 (bit time 432 clocks = 8640 ns at 50 MHz) -> rx_ready=1 within 9.5 bit times + 60 clocks of the start edge, rx_data=0x55, rx_ferr=0, rx_ovr=0. rx_ack pulse -> rx_ready=0 next clock.
- rxd low for 40 clocks, then high (glitch shorter than half a bit) -> stays/returns to IDLE, rx_ready=0, rx_busy back to 0 within 1 bit time.
- Send 0xA3 with the stop bit forced 0, then hold rxd low for 3 bit times -> rx_ferr=1 exactly once, rx_ready=0, rx_busy=1 until the line returns high. Next valid 0x0F -> rx_data=0x0F, rx_ready=1, rx_ferr=0.
- Send 0x12 then 0x34 with no rx_ack -> rx_data=0x34, rx_ready=1, rx_ovr=1. Then rx_ack asserted on the exact cycle 0x56 loads -> rx_data=0x56, rx_ready=1, rx_ovr=0.
- Assert wb_rst_i during bit 4 of 0xFF -> all outputs 0 immediately. Release, send 0x81 -> rx_data=0x81, no stale bits.
- With CONFIG_UART_RX_MAJORITY_EN: send 0x00 with a 1-tick (27-clock) high pulse centred on ph==7 of bit 3 -> rx_data=0x00. Without the macro, the same stimulus -> rx_data=0x08.
